// File: rtl/cx_dma_types.sv
// -----------------------------------------------------------------------------
// cx_dma_types
// Shared types for the CX DMA unit and its per-CXU front ends.
//   - track_id_t / track_entry_t : tracker ID and {end, base} tracker entry
//   - burst_state_t              : state encoding of cx_dma_burst_gen
//   - dma_desc_t                 : CXU transfer descriptor {addr, len, dir}
//   - beat_size()                : AXI AxSIZE encoding for a beat width in bytes
// -----------------------------------------------------------------------------
package cx_dma_types;

   localparam int CX_ADDR_WIDTH     = 32;
   localparam int CX_LEN_WIDTH      = 16;
   localparam int CX_TRACK_ID_WIDTH = 4;

   typedef logic [CX_TRACK_ID_WIDTH-1:0] track_id_t;

   typedef struct packed {
      logic [CX_ADDR_WIDTH-1:0] end_addr;
      logic [CX_ADDR_WIDTH-1:0] base_addr;
   } track_entry_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CALC    = 3'd1,
      ST_ALLOC   = 3'd2,
      ST_WAIT_ID = 3'd3,
      ST_ISSUE   = 3'd4
   } burst_state_t;

   typedef struct packed {
      logic [CX_ADDR_WIDTH-1:0] addr;
      logic [CX_LEN_WIDTH-1:0]  len;
      logic                     dir;   // 0 = read, 1 = write
   } dma_desc_t;

   // AxSIZE field: log2 of the number of bytes per beat.
   function automatic logic [2:0] beat_size(input int beat_bytes);
      return 3'($clog2(beat_bytes));
   endfunction

endpackage

// File: rtl/cx_dma_burst_calc.sv
// -----------------------------------------------------------------------------
// cx_dma_burst_calc
// Combinational length of the next INCR burst of a transfer:
//   bytes = min(remaining, MAX_BEATS*BEAT_BYTES, BOUNDARY - (addr mod BOUNDARY))
//   end   = addr + bytes - 1
// Ports:
//   i_addr      : current burst start address
//   i_remaining : bytes still to transfer (non-zero when used)
//   o_bytes     : bytes covered by this burst
//   o_end       : address of the last byte of this burst
// -----------------------------------------------------------------------------
module cx_dma_burst_calc #(
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int BEAT_BYTES = 8,
   parameter int MAX_BEATS  = 16,
   parameter int BOUNDARY   = 4096
) (
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [LEN_WIDTH-1:0]  i_remaining,
   output logic [LEN_WIDTH-1:0]  o_bytes,
   output logic [ADDR_WIDTH-1:0] o_end
);

   // One bit wider than the widest operand so that the boundary room
   // (which may equal BOUNDARY itself) and the end sum never overflow
   // before the final truncation.
   localparam int CW = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;

   logic [CW-1:0] rem_w;
   logic [CW-1:0] cap_w;
   logic [CW-1:0] room_w;
   logic [CW-1:0] lim_w;
   logic [CW-1:0] bytes_w;
   logic [CW-1:0] end_w;

   always_comb begin
      rem_w   = CW'(i_remaining);
      cap_w   = CW'(MAX_BEATS * BEAT_BYTES);
      room_w  = CW'(BOUNDARY) - CW'(i_addr & ADDR_WIDTH'(BOUNDARY - 1));
      lim_w   = (rem_w < cap_w) ? rem_w : cap_w;
      bytes_w = (lim_w < room_w) ? lim_w : room_w;
      // A transfer running past the top of the address space wraps here;
      // callers are expected never to request one.
      end_w   = CW'(i_addr) + bytes_w - CW'(1);
   end

   // bytes_w never exceeds the remaining length, so it fits LEN_WIDTH.
   assign o_bytes = LEN_WIDTH'(bytes_w);
   assign o_end   = ADDR_WIDTH'(end_w);

endmodule

// File: rtl/cx_dma_burst_gen.sv
// -----------------------------------------------------------------------------
// cx_dma_burst_gen
// Per-CXU DMA request generator. Accepts one descriptor {addr, len, dir},
// splits it into AXI-legal INCR bursts, allocates a tracker entry for each
// burst and issues the read or write request tagged with the returned ID.
//
// Optional feature macro: CX_DMA_BURST_STATS_EN
//   defined   : o_burst_cnt counts ISSUE handshakes (wraps at 2^16)
//   undefined : o_burst_cnt tied to 0, no counter built
//
// Ports:
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   s_desc_*                       : descriptor in (valid/ready, addr, len, dir)
//   m_alloc_valid/ready/data       : tracker alloc request, data = {end, base}
//   s_alloc_resp_valid/ready/data  : tracker alloc response (track ID)
//   m_rd_valid/ready, m_wr_valid/ready : memory request handshakes
//   m_req_base/end/size/id         : burst first/last byte, AxSIZE, track ID
//   o_busy                         : descriptor in progress
//   o_done / o_err                 : one-cycle completion / rejection pulses
//   o_burst_cnt                    : issued-burst counter (see macro above)
// -----------------------------------------------------------------------------
module cx_dma_burst_gen
   import cx_dma_types::*;
#(
   parameter int ADDR_WIDTH     = CX_ADDR_WIDTH,
   parameter int LEN_WIDTH      = CX_LEN_WIDTH,
   parameter int BEAT_BYTES     = 8,
   parameter int MAX_BEATS      = 16,
   parameter int BOUNDARY       = 4096,
   parameter int TRACK_ID_WIDTH = CX_TRACK_ID_WIDTH
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,

   input  logic                      s_desc_valid,
   output logic                      s_desc_ready,
   input  logic [ADDR_WIDTH-1:0]     s_desc_addr,
   input  logic [LEN_WIDTH-1:0]      s_desc_len,
   input  logic                      s_desc_dir,

   output logic                      m_alloc_valid,
   input  logic                      m_alloc_ready,
   output logic [2*ADDR_WIDTH-1:0]   m_alloc_data,

   input  logic                      s_alloc_resp_valid,
   output logic                      s_alloc_resp_ready,
   input  logic [TRACK_ID_WIDTH-1:0] s_alloc_resp_data,

   output logic                      m_rd_valid,
   input  logic                      m_rd_ready,
   output logic                      m_wr_valid,
   input  logic                      m_wr_ready,
   output logic [ADDR_WIDTH-1:0]     m_req_base,
   output logic [ADDR_WIDTH-1:0]     m_req_end,
   output logic [2:0]                m_req_size,
   output logic [TRACK_ID_WIDTH-1:0] m_req_id,

   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_err,
   output logic [15:0]               o_burst_cnt
);

   localparam logic [2:0] REQ_SIZE = beat_size(BEAT_BYTES);

   burst_state_t              state_q, state_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;     // start of the next burst
   logic [LEN_WIDTH-1:0]      rem_q, rem_d;       // bytes not yet issued
   logic                      dir_q, dir_d;
   logic [ADDR_WIDTH-1:0]     base_q, base_d;     // current burst first byte
   logic [ADDR_WIDTH-1:0]     end_q, end_d;       // current burst last byte
   logic [LEN_WIDTH-1:0]      bytes_q, bytes_d;   // current burst size
   logic [TRACK_ID_WIDTH-1:0] id_q, id_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;

   logic [LEN_WIDTH-1:0]      calc_bytes;
   logic [ADDR_WIDTH-1:0]     calc_end;
   logic                      desc_misaligned;
   logic                      req_ready;

   // Burst length for the current address / remaining count. Only sampled
   // in CALC, where addr_q and rem_q are stable.
   cx_dma_burst_calc #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH),
      .BEAT_BYTES (BEAT_BYTES),
      .MAX_BEATS  (MAX_BEATS),
      .BOUNDARY   (BOUNDARY)
   ) u_calc (
      .i_addr      (addr_q),
      .i_remaining (rem_q),
      .o_bytes     (calc_bytes),
      .o_end       (calc_end)
   );

   assign desc_misaligned = ((s_desc_addr & ADDR_WIDTH'(BEAT_BYTES - 1)) != '0) ||
                            ((s_desc_len  & LEN_WIDTH'(BEAT_BYTES - 1))  != '0);

   // Only the port matching the latched direction is ever raised.
   assign req_ready = dir_q ? m_wr_ready : m_rd_ready;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      dir_d   = dir_q;
      base_d  = base_q;
      end_d   = end_q;
      bytes_d = bytes_q;
      id_d    = id_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (s_desc_valid) begin
               addr_d = s_desc_addr;
               rem_d  = s_desc_len;
               dir_d  = s_desc_dir;
               if (desc_misaligned) begin
                  err_d = 1'b1;
               end else if (s_desc_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_CALC;
               end
            end
         end

         ST_CALC: begin
            base_d  = addr_q;
            end_d   = calc_end;
            bytes_d = calc_bytes;
            state_d = ST_ALLOC;
         end

         ST_ALLOC: begin
            if (m_alloc_ready) begin
               state_d = ST_WAIT_ID;
            end
         end

         ST_WAIT_ID: begin
            if (s_alloc_resp_valid) begin
               id_d    = s_alloc_resp_data;
               state_d = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            if (req_ready) begin
               addr_d = addr_q + ADDR_WIDTH'(bytes_q);
               rem_d  = rem_q - bytes_q;
               if (rem_q == bytes_q) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_CALC;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         dir_q   <= 1'b0;
         base_q  <= '0;
         end_q   <= '0;
         bytes_q <= '0;
         id_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
         base_q  <= base_d;
         end_q   <= end_d;
         bytes_q <= bytes_d;
         id_q    <= id_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Handshake controls decode the registered state only, so no input
   // valid/ready can reach an output valid within the same cycle.
   assign s_desc_ready       = (state_q == ST_IDLE);
   assign m_alloc_valid      = (state_q == ST_ALLOC);
   assign s_alloc_resp_ready = (state_q == ST_WAIT_ID);
   assign m_rd_valid         = (state_q == ST_ISSUE) && !dir_q;
   assign m_wr_valid         = (state_q == ST_ISSUE) &&  dir_q;
   assign o_busy             = (state_q != ST_IDLE);

   assign m_alloc_data = {end_q, base_q};
   assign m_req_base   = base_q;
   assign m_req_end    = end_q;
   assign m_req_size   = REQ_SIZE;
   assign m_req_id     = id_q;
   assign o_done       = done_q;
   assign o_err        = err_q;

`ifdef CX_DMA_BURST_STATS_EN
   logic [15:0] burst_cnt_q, burst_cnt_d;
   logic        burst_fire;

   assign burst_fire = (state_q == ST_ISSUE) && req_ready;

   always_comb begin
      burst_cnt_d = burst_cnt_q;
      if (burst_fire) begin
         burst_cnt_d = burst_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         burst_cnt_q <= '0;
      end else begin
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign o_burst_cnt = burst_cnt_q;
`else
   assign o_burst_cnt = '0;
`endif

endmodule

// File: tb/tb_cx_dma_burst_gen.sv
// -----------------------------------------------------------------------------
// tb_cx_dma_burst_gen
// Self-checking bench for cx_dma_burst_gen: a table of directed descriptors,
// hand-written stall and mid-flight reset sequences, and randomized
// descriptors with random downstream readies. Expected bursts come from a
// plain integer model of the burst-splitting rules.
// -----------------------------------------------------------------------------
module tb_cx_dma_burst_gen;
   import cx_dma_types::*;

   localparam int MAX_BYTES = 16 * 8;
   localparam int BOUND     = 4096;

   logic        clk;
   logic        i_rst_n;
   logic        s_desc_valid, s_desc_ready;
   logic [31:0] s_desc_addr;
   logic [15:0] s_desc_len;
   logic        s_desc_dir;
   logic        m_alloc_valid, m_alloc_ready;
   logic [63:0] m_alloc_data;
   logic        s_alloc_resp_valid, s_alloc_resp_ready;
   logic [3:0]  s_alloc_resp_data;
   logic        m_rd_valid, m_rd_ready, m_wr_valid, m_wr_ready;
   logic [31:0] m_req_base, m_req_end;
   logic [2:0]  m_req_size;
   logic [3:0]  m_req_id;
   logic        o_busy, o_done, o_err;
   logic [15:0] o_burst_cnt;

   cx_dma_burst_gen dut (
      .i_clk              (clk),
      .i_rst_n            (i_rst_n),
      .s_desc_valid       (s_desc_valid),
      .s_desc_ready       (s_desc_ready),
      .s_desc_addr        (s_desc_addr),
      .s_desc_len         (s_desc_len),
      .s_desc_dir         (s_desc_dir),
      .m_alloc_valid      (m_alloc_valid),
      .m_alloc_ready      (m_alloc_ready),
      .m_alloc_data       (m_alloc_data),
      .s_alloc_resp_valid (s_alloc_resp_valid),
      .s_alloc_resp_ready (s_alloc_resp_ready),
      .s_alloc_resp_data  (s_alloc_resp_data),
      .m_rd_valid         (m_rd_valid),
      .m_rd_ready         (m_rd_ready),
      .m_wr_valid         (m_wr_valid),
      .m_wr_ready         (m_wr_ready),
      .m_req_base         (m_req_base),
      .m_req_end          (m_req_end),
      .m_req_size         (m_req_size),
      .m_req_id           (m_req_id),
      .o_busy             (o_busy),
      .o_done             (o_done),
      .o_err              (o_err),
      .o_burst_cnt        (o_burst_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------- records
   typedef struct {
      dma_desc_t desc;
      bit        exp_err;
      int        exp_n;     // bursts expected on the request port
   } vec_t;

   typedef struct {
      logic        dir;
      logic [31:0] base;
      logic [31:0] last;
      logic [2:0]  size;
      logic [3:0]  id;
   } req_t;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [31:0] exp_base[$];
   logic [31:0] exp_end[$];
   logic [63:0] obs_alloc[$];
   req_t        obs_req[$];
   logic [3:0]  sent_ids[$];
   int          done_cnt, err_cnt, both_cnt;
   int          pending;
   bit          resp_handshook;
   bit          resp_auto;
   int          resp_stall;
   int          wait_cnt;
   logic [3:0]  next_id;
   bit          rand_rdy;
   int          exp_cnt;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: walk the transfer with plain integers, cutting each burst at
   // the per-burst byte cap and at the next boundary multiple.
   function automatic void model_bursts(input longint a, input longint l);
      longint b, room;
      exp_base.delete();
      exp_end.delete();
      while (l > 0) begin
         b = l;
         if (b > MAX_BYTES) b = MAX_BYTES;
         room = BOUND - (a % BOUND);
         if (b > room) b = room;
         exp_base.push_back(32'(a));
         exp_end.push_back(32'(a + b - 1));
         a += b;
         l -= b;
      end
   endfunction

   function automatic logic [15:0] exp_burst_cnt();
`ifdef CX_DMA_BURST_STATS_EN
      return 16'(exp_cnt);
`else
      return 16'd0;
`endif
   endfunction

   function automatic vec_t mk(input logic [31:0] a, input logic [15:0] l,
                               input logic d, input bit e, input int n);
      vec_t v;
      v.desc.addr = a;
      v.desc.len  = l;
      v.desc.dir  = d;
      v.exp_err   = e;
      v.exp_n     = n;
      return v;
   endfunction

   // ---------------------------------------------------------------- monitor
   initial begin
      forever begin
         @(negedge clk);
         if (m_alloc_valid && m_alloc_ready) begin
            obs_alloc.push_back(m_alloc_data);
            pending++;
         end
         if (s_alloc_resp_valid && s_alloc_resp_ready) resp_handshook = 1'b1;
         if (m_rd_valid && m_wr_valid) both_cnt++;
         if (m_rd_valid && m_rd_ready)
            obs_req.push_back('{1'b0, m_req_base, m_req_end, m_req_size, m_req_id});
         if (m_wr_valid && m_wr_ready)
            obs_req.push_back('{1'b1, m_req_base, m_req_end, m_req_size, m_req_id});
         if (o_done) done_cnt++;
         if (o_err)  err_cnt++;
      end
   end

   // ------------------------------------------------------- tracker responder
   initial begin
      s_alloc_resp_valid = 1'b0;
      s_alloc_resp_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (resp_auto) begin
            if (resp_handshook) begin
               s_alloc_resp_valid = 1'b0;
               resp_handshook     = 1'b0;
            end
            if (!s_alloc_resp_valid && pending > 0) begin
               if (wait_cnt < resp_stall) begin
                  wait_cnt++;
               end else begin
                  s_alloc_resp_valid = 1'b1;
                  s_alloc_resp_data  = next_id;
                  sent_ids.push_back(next_id);
                  next_id  = next_id + 4'd3;
                  pending--;
                  wait_cnt = 0;
               end
            end
         end
      end
   end

   // ------------------------------------------------------ downstream readies
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) begin
            m_alloc_ready = ($urandom_range(0, 3) != 0);
            m_rd_ready    = ($urandom_range(0, 3) != 0);
            m_wr_ready    = ($urandom_range(0, 3) != 0);
         end else begin
            m_alloc_ready = 1'b1;
            m_rd_ready    = 1'b1;
            m_wr_ready    = 1'b1;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ drive tasks
   task automatic clear_obs();
      obs_alloc.delete();
      obs_req.delete();
      sent_ids.delete();
      done_cnt = 0;
      err_cnt  = 0;
      both_cnt = 0;
   endtask

   task automatic send_desc(input logic [31:0] a, input logic [15:0] l, input logic d,
                            input string nm);
      bit ok = 1'b0;
      @(posedge clk);
      #1;
      s_desc_valid = 1'b1;
      s_desc_addr  = a;
      s_desc_len   = l;
      s_desc_dir   = d;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (s_desc_ready) begin ok = 1'b1; break; end
      end
      n_vec++;
      if (!ok) begin
         n_miss++;
         $display("FAIL %s accept: got no s_desc_ready, required one within 200 cycles", nm);
      end
      @(posedge clk);
      #1;
      s_desc_valid = 1'b0;
   endtask

   task automatic run_desc(input vec_t v, input string nm);
      bit fin = 1'b0;
      int n;
      model_bursts(longint'(v.desc.addr), longint'(v.desc.len));
      clear_obs();
      send_desc(v.desc.addr, v.desc.len, v.desc.dir, nm);
      for (int i = 0; i < 5000; i++) begin
         if (done_cnt + err_cnt > 0) begin fin = 1'b1; break; end
         @(negedge clk);
         #1;
      end
      n_vec++;
      if (!fin) begin
         n_miss++;
         $display("FAIL %s finish: got no o_done/o_err, required one within 5000 cycles", nm);
      end
      if (v.exp_err) check({nm, " ready_after_err"}, 64'(s_desc_ready), 64'd1);
      repeat (3) begin @(negedge clk); #1; end
      if (!v.exp_err) exp_cnt += v.exp_n;
      check({nm, " err_pulses"},  64'(err_cnt),  64'(v.exp_err ? 1 : 0));
      check({nm, " done_pulses"}, 64'(done_cnt), 64'(v.exp_err ? 0 : 1));
      check({nm, " n_alloc"},     64'(obs_alloc.size()), 64'(v.exp_n));
      check({nm, " n_req"},       64'(obs_req.size()),   64'(v.exp_n));
      check({nm, " both_valid"},  64'(both_cnt), 64'd0);
      check({nm, " busy_end"},    64'(o_busy), 64'd0);
      check({nm, " burst_cnt"},   64'(o_burst_cnt), 64'(exp_burst_cnt()));
      n = v.exp_n;
      if (n > obs_alloc.size()) n = obs_alloc.size();
      if (n > obs_req.size())   n = obs_req.size();
      if (n > exp_base.size())  n = exp_base.size();
      if (n > sent_ids.size())  n = sent_ids.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s b%0d alloc", nm, i), obs_alloc[i], {exp_end[i], exp_base[i]});
         check($sformatf("%s b%0d base", nm, i), 64'(obs_req[i].base), 64'(exp_base[i]));
         check($sformatf("%s b%0d end", nm, i),  64'(obs_req[i].last), 64'(exp_end[i]));
         check($sformatf("%s b%0d dir", nm, i),  64'(obs_req[i].dir),  64'(v.desc.dir));
         check($sformatf("%s b%0d size", nm, i), 64'(obs_req[i].size), 64'd3);
         check($sformatf("%s b%0d id", nm, i),   64'(obs_req[i].id),   64'(sent_ids[i]));
      end
      $display("desc %s addr=0x%08h len=%0d dir=%0d bursts=%0d err=%0d done=%0d",
               nm, v.desc.addr, v.desc.len, v.desc.dir, obs_req.size(), err_cnt, done_cnt);
   endtask

   task automatic wait_alloc(input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (obs_alloc.size() > 0) begin ok = 1'b1; break; end
      end
      n_vec++;
      if (!ok) begin
         n_miss++;
         $display("FAIL %s alloc: got no alloc handshake, required one within 200 cycles", nm);
      end
   endtask

   task automatic check_idle_outputs(input string nm);
      check({nm, " desc_ready"},  64'(s_desc_ready), 64'd1);
      check({nm, " alloc_valid"}, 64'(m_alloc_valid), 64'd0);
      check({nm, " resp_ready"},  64'(s_alloc_resp_ready), 64'd0);
      check({nm, " rd_valid"},    64'(m_rd_valid), 64'd0);
      check({nm, " wr_valid"},    64'(m_wr_valid), 64'd0);
      check({nm, " busy"},        64'(o_busy), 64'd0);
      check({nm, " done"},        64'(o_done), 64'd0);
      check({nm, " err"},         64'(o_err), 64'd0);
      check({nm, " alloc_data"},  m_alloc_data, 64'd0);
      check({nm, " req_base"},    64'(m_req_base), 64'd0);
      check({nm, " req_end"},     64'(m_req_end), 64'd0);
      check({nm, " req_id"},      64'(m_req_id), 64'd0);
      check({nm, " burst_cnt"},   64'(o_burst_cnt), 64'd0);
   endtask

   // -------------------------------------------------------------- main test
   vec_t vecs[10];

   initial begin
      vecs[0] = mk(32'h0000_1000, 16'd64,  1'b0, 1'b0, 1);
      vecs[1] = mk(32'h0000_0FC0, 16'd256, 1'b1, 1'b0, 3);
      vecs[2] = mk(32'h0000_1004, 16'd16,  1'b0, 1'b1, 0);
      vecs[3] = mk(32'h0000_1000, 16'd0,   1'b0, 1'b0, 0);
      vecs[4] = mk(32'h0000_1000, 16'd12,  1'b1, 1'b1, 0);
      vecs[5] = mk(32'h0000_0FF8, 16'd16,  1'b0, 1'b0, 2);
      vecs[6] = mk(32'h0000_2000, 16'd128, 1'b1, 1'b0, 1);
      vecs[7] = mk(32'h0000_2000, 16'd136, 1'b0, 1'b0, 2);
      vecs[8] = mk(32'h0000_0000, 16'd8,   1'b1, 1'b0, 1);
      vecs[9] = mk(32'h0000_1FF0, 16'd400, 1'b1, 1'b0, 4);

      i_rst_n = 1'b0;
      s_desc_valid = 1'b0;
      s_desc_addr = '0;
      s_desc_len = '0;
      s_desc_dir = 1'b0;
      m_alloc_ready = 1'b1;
      m_rd_ready = 1'b1;
      m_wr_ready = 1'b1;
      pending = 0;
      resp_handshook = 1'b0;
      resp_auto = 1'b1;
      resp_stall = 0;
      wait_cnt = 0;
      next_id = 4'h1;
      rand_rdy = 1'b0;
      exp_cnt = 0;
      clear_obs();

      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check_idle_outputs("reset");
      @(posedge clk);
      #1;
      i_rst_n = 1'b1;
      @(negedge clk);
      #1;
      check_idle_outputs("post_reset");

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         run_desc(vecs[i], $sformatf("vec%0d", i));
      end

      // Alloc response held off for 10 cycles.
      clear_obs();
      resp_auto = 1'b0;
      send_desc(32'h0000_3000, 16'd8, 1'b0, "stall");
      wait_alloc("stall");
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("stall c%0d resp_ready", k), 64'(s_alloc_resp_ready), 64'd1);
         check($sformatf("stall c%0d rd_valid", k),   64'(m_rd_valid), 64'd0);
         check($sformatf("stall c%0d wr_valid", k),   64'(m_wr_valid), 64'd0);
         check($sformatf("stall c%0d desc_ready", k), 64'(s_desc_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      s_alloc_resp_valid = 1'b1;
      s_alloc_resp_data  = 4'hA;
      @(negedge clk);
      #1;
      check("stall resp_accept", 64'(s_alloc_resp_ready), 64'd1);
      check("stall rd_before", 64'(m_rd_valid), 64'd0);
      @(posedge clk);
      #1;
      s_alloc_resp_valid = 1'b0;
      @(negedge clk);
      #1;
      check("stall rd_next_cycle", 64'(m_rd_valid), 64'd1);
      check("stall req_id", 64'(m_req_id), 64'hA);
      check("stall req_base", 64'(m_req_base), 64'h3000);
      check("stall req_end", 64'(m_req_end), 64'h3007);
      repeat (3) begin @(negedge clk); #1; end
      exp_cnt += 1;
      check("stall done_pulses", 64'(done_cnt), 64'd1);
      check("stall burst_cnt", 64'(o_burst_cnt), 64'(exp_burst_cnt()));
      $display("seq stall bursts=%0d done=%0d", obs_req.size(), done_cnt);
      pending = 0;
      resp_handshook = 1'b0;
      resp_auto = 1'b1;

      // Reset while waiting for a track ID.
      clear_obs();
      resp_auto = 1'b0;
      send_desc(32'h0000_4000, 16'd32, 1'b1, "rst");
      wait_alloc("rst");
      @(negedge clk);
      #1;
      check("rst in_wait_id", 64'(s_alloc_resp_ready), 64'd1);
      @(posedge clk);
      #2;
      i_rst_n = 1'b0;
      #1;
      check_idle_outputs("rst_async");
      repeat (2) @(posedge clk);
      #1;
      i_rst_n = 1'b1;
      pending = 0;
      resp_handshook = 1'b0;
      exp_cnt = 0;
      resp_auto = 1'b1;
      $display("seq rst reqs_before_reset=%0d", obs_req.size());
      run_desc(mk(32'h0000_4000, 16'd32, 1'b1, 1'b0, 1), "after_rst");

      // Randomized descriptors with random readies and response delays.
      rand_rdy = 1'b1;
      for (int t = 0; t < 40; t++) begin
         logic [31:0] a;
         logic [15:0] l;
         bit          e;
         a = 32'($urandom_range(0, 32'h7FFF)) & ~32'h7;
         l = 16'($urandom_range(0, 80) * 8);
         if ($urandom_range(0, 7) == 0) a = a | 32'h4;
         if ($urandom_range(0, 7) == 0) l = l | 16'h3;
         e = (a[2:0] != 3'd0) || (l[2:0] != 3'd0);
         resp_stall = int'($urandom_range(0, 3));
         model_bursts(longint'(a), longint'(l));
         run_desc(mk(a, l, 1'($urandom_range(0, 1)), e, e ? 0 : exp_base.size()),
                  $sformatf("rnd%0d", t));
      end
      rand_rdy = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
